// File: rtl/dual_slot_rr_arbiter_pkg.sv
// Shared definitions for the dual-slot round-robin arbiter: defaults, slot
// state encoding and the modulo-N index increment used by the pointer.
package dual_slot_rr_arbiter_pkg;

    localparam int N_REQ_DEF = 12;
    localparam int IDX_W_DEF = 4;

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_BUSY = 1'b1
    } slot_state_t;

    // Wraps at n rather than at a power of two.
    function automatic int idx_inc_mod(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dual_slot_rr_arbiter_rr_priority_pick.sv
// Combinational rotating-priority search: returns the first set bit of vec
// scanning from ptr upward and wrapping at N_REQ.
module rr_priority_pick #(
    parameter int N_REQ = 12,
    parameter int IDX_W = 4
) (
    input  logic [N_REQ-1:0] vec,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    int pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!found && (|(vec & (ONE << pos)))) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/dual_slot_rr_arbiter.sv
// Two held service slots shared among N_REQ requesters; idle slots are
// filled each cycle by rotating priority and released by their done pulse.
module dual_slot_rr_arbiter
    import dual_slot_rr_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done0,
    input  logic             done1,
    output logic             gnt0_valid,
    output logic [IDX_W-1:0] gnt0_idx,
    output logic             gnt1_valid,
    output logic [IDX_W-1:0] gnt1_idx,
    output logic [N_REQ-1:0] gnt
);

    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    slot_state_t      state0, state0_n;
    slot_state_t      state1, state1_n;
    logic [IDX_W-1:0] idx0, idx0_n;
    logic [IDX_W-1:0] idx1, idx1_n;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
    logic [N_REQ-1:0] gnt_q, gnt_n;

    logic [N_REQ-1:0] busy_mask;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] second_vec;
    logic             found_a, found_b;
    logic [IDX_W-1:0] idx_a, idx_b;

    // A requester already holding a slot is never offered the other one.
    always_comb begin
        busy_mask = '0;
        if (state0 == SLOT_BUSY) begin
            busy_mask = busy_mask | (ONE << idx0);
        end
        if (state1 == SLOT_BUSY) begin
            busy_mask = busy_mask | (ONE << idx1);
        end
        eligible   = req & ~busy_mask;
        second_vec = eligible & ~(ONE << idx_a);
    end

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick_first (
        .vec   (eligible),
        .ptr   (rr_ptr),
        .found (found_a),
        .idx   (idx_a)
    );

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick_second (
        .vec   (second_vec),
        .ptr   (rr_ptr),
        .found (found_b),
        .idx   (idx_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state0 <= SLOT_IDLE;
            state1 <= SLOT_IDLE;
            idx0   <= '0;
            idx1   <= '0;
            rr_ptr <= '0;
            gnt_q  <= '0;
        end else begin
            state0 <= state0_n;
            state1 <= state1_n;
            idx0   <= idx0_n;
            idx1   <= idx1_n;
            rr_ptr <= rr_ptr_n;
            gnt_q  <= gnt_n;
        end
    end

    // Release decisions use the current state, so a slot freed this edge
    // cannot also be refilled this edge.
    always_comb begin
        state0_n = state0;
        state1_n = state1;
        idx0_n   = idx0;
        idx1_n   = idx1;
        rr_ptr_n = rr_ptr;

        if (state0 == SLOT_BUSY && done0) begin
            state0_n = SLOT_IDLE;
            idx0_n   = '0;
        end
        if (state1 == SLOT_BUSY && done1) begin
            state1_n = SLOT_IDLE;
            idx1_n   = '0;
        end

        if (state0 == SLOT_IDLE && state1 == SLOT_IDLE) begin
            if (found_a) begin
                state0_n = SLOT_BUSY;
                idx0_n   = idx_a;
                if (found_b) begin
                    state1_n = SLOT_BUSY;
                    idx1_n   = idx_b;
                    rr_ptr_n = IDX_W'(idx_inc_mod(int'(idx_b), N_REQ));
                end else begin
                    rr_ptr_n = IDX_W'(idx_inc_mod(int'(idx_a), N_REQ));
                end
            end
        end else if (state0 == SLOT_IDLE) begin
            if (found_a) begin
                state0_n = SLOT_BUSY;
                idx0_n   = idx_a;
                rr_ptr_n = IDX_W'(idx_inc_mod(int'(idx_a), N_REQ));
            end
        end else if (state1 == SLOT_IDLE) begin
            if (found_a) begin
                state1_n = SLOT_BUSY;
                idx1_n   = idx_a;
                rr_ptr_n = IDX_W'(idx_inc_mod(int'(idx_a), N_REQ));
            end
        end

        gnt_n = '0;
        if (state0_n == SLOT_BUSY) begin
            gnt_n = gnt_n | (ONE << idx0_n);
        end
        if (state1_n == SLOT_BUSY) begin
            gnt_n = gnt_n | (ONE << idx1_n);
        end
    end

    assign gnt0_valid = (state0 == SLOT_BUSY);
    assign gnt1_valid = (state1 == SLOT_BUSY);
    assign gnt0_idx   = idx0;
    assign gnt1_idx   = idx1;
    assign gnt        = gnt_q;

endmodule
